shift_left_2: RTL and testbench
===============================

# shift_left_2

Registered shift-left-by-2 stage for the MIPS datapath. It converts the 26-bit instruction index field (instr[25:0]) into a 28-bit byte offset by appending two zero LSBs. It also forms the full 32-bit jump target by prefixing the upper PC bits. It sits between instruction decode and the PC-select mux, with one pipeline register and a valid qualifier.

## Interface
Parameters:
- IN_W, default 26: width of input field.
- SHIFT, default 2: fixed left-shift amount. Zeros are inserted at the LSBs.
- PC_HI_W, default 4: number of PC upper bits prefixed to form the jump target.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- signal  input  IN_W  field to shift (instr[25:0]).
- valid_in  input  1  signal/pc_hi qualifier; sampled on the rising edge of clk.
- pc_hi  input  PC_HI_W  upper bits of PC+4 (pc_plus4[31:28]).
- out  output  IN_W+SHIFT  registered {signal, SHIFT'b0}.
- jump_target  output  PC_HI_W+IN_W+SHIFT  registered {pc_hi, signal, SHIFT'b0}.
- valid_out  output  1  out/jump_target hold a captured result.

## Operation
- Shift is lossless. out is IN_W+SHIFT bits wide, so no input bit is discarded.
  - out[IN_W+SHIFT-1:SHIFT] = signal.
  - out[SHIFT-1:0] = 0.
- jump_target = {pc_hi, out}. With default parameters this is 32 bits.
- Capture rule:
  - On each rising clk edge with valid_in=1, load out and jump_target from the current inputs and set valid_out=1.
  - With valid_in=0, out and jump_target hold their previous values and valid_out=0.
- The shift is a pure wire concatenation. It uses no arithmetic, no sign extension and no rotation.
- There is no stall or back-pressure input. Every valid input is accepted.
- X/Z on signal while valid_in=0 must not propagate to the outputs.

## Timing
- Latency is 1 clock. An input sampled at edge N appears on out, jump_target and valid_out after edge N.
- Throughput is 1 result per clock. Back-to-back valid_in cycles each update the outputs.
- Reset:
  - While reset=1, regardless of clk: out=0, jump_target=0, valid_out=0.
  - Reset assertion takes effect immediately. It does not wait for a clock edge.
- Reset mid-operation: a value captured before reset is lost. The first capture after deassertion is the first rising edge with reset=0 and valid_in=1.
- Reset and a clock edge together: reset wins and the outputs stay 0.
- No combinational path exists from inputs to outputs.

## Test plan
- Reset behaviour:
  - Stimulus: assert reset with arbitrary signal and valid_in=1.
  - Required response: out=0, jump_target=0 and valid_out=0 immediately, and for every clock while reset is held.
- Basic shift, value 1111:
  - Stimulus: signal=1111 (decimal, 0b10001010111), pc_hi=4'h0, valid_in=1.
  - Required response: one clock later out=4444 (0b1000101011100), jump_target=32'd4444, valid_out=1.
- Back-to-back update, value 1010:
  - Stimulus: at the next edge, signal=1010 (0b1111110010).
  - Required response: out=4040 (0b111111001000) one clock later, valid_out remains 1.
- Full-width boundary:
  - Stimulus: signal=26'h3FFFFFF, pc_hi=4'hA.
  - Required response: out=28'hFFFFFFC, jump_target=32'hAFFFFFFC. Check that the MSBs are retained and the two LSBs are 0.
- Hold behaviour:
  - Stimulus: valid_in=0 while signal toggles randomly, including X.
  - Required response: out and jump_target unchanged, valid_out=0.
- Reset mid-stream:
  - Stimulus: capture signal=26'h1 (out=4), then pulse reset asynchronously between edges.
  - Required response: outputs clear to 0 without waiting for a clock edge. After release, the next valid_in=1 capture of 26'h2 gives out=8.

Source files
------------

// File: rtl/shift_left_2.sv
// Registered shift-left-by-2 stage: turns the 26-bit instruction index into a
// byte offset and forms the full jump target with the upper PC bits prefixed.
module shift_left_2 #(
   parameter int unsigned IN_W    = 26,
   parameter int unsigned SHIFT   = 2,
   parameter int unsigned PC_HI_W = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [IN_W-1:0]                  signal,
   input  logic                             valid_in,
   input  logic [PC_HI_W-1:0]               pc_hi,
   output logic [IN_W+SHIFT-1:0]            out,
   output logic [PC_HI_W+IN_W+SHIFT-1:0]    jump_target,
   output logic                             valid_out
);

   localparam int unsigned OUT_W = IN_W + SHIFT;
   localparam int unsigned JT_W  = PC_HI_W + OUT_W;

   logic [OUT_W-1:0] shifted_c;
   logic [JT_W-1:0]  target_c;

   // Pure concatenation: no arithmetic, sign extension or rotation.
   assign shifted_c = {signal, {SHIFT{1'b0}}};
   assign target_c  = {pc_hi, shifted_c};

   // Data registers load only on valid_in, so junk on signal while idle never reaches the outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out         <= '0;
         jump_target <= '0;
         valid_out   <= 1'b0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) begin
            out         <= shifted_c;
            jump_target <= target_c;
         end
      end
   end

endmodule

// File: tb/tb_shift_left_2.sv
// Directed bench for shift_left_2: reset, shifts, full-width boundary, hold
// and asynchronous reset mid-stream, all against hand-computed values.
module tb_shift_left_2;

   logic        clk;
   logic        reset;
   logic [25:0] signal;
   logic        valid_in;
   logic [3:0]  pc_hi;
   logic [27:0] out;
   logic [31:0] jump_target;
   logic        valid_out;

   int unsigned n_vec;
   int unsigned n_bad;

   logic [27:0] held_out;
   logic [31:0] held_jt;

   shift_left_2 #(.IN_W(26), .SHIFT(2), .PC_HI_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .signal      (signal),
      .valid_in    (valid_in),
      .pc_hi       (pc_hi),
      .out         (out),
      .jump_target (jump_target),
      .valid_out   (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [27:0] e_out,
                            input logic [31:0] e_jt, input logic e_v);
      check({tag, ".out"},       32'(out),         32'(e_out));
      check({tag, ".jt"},        jump_target,      e_jt);
      check({tag, ".valid_out"}, 32'(valid_out),   32'(e_v));
   endtask

   initial begin
      n_vec    = 0;
      n_bad    = 0;
      reset    = 1'b1;
      valid_in = 1'b1;
      signal   = 26'h2AB_CDEF;
      pc_hi    = 4'hF;

      // Reset effective before any clock edge and held across edges.
      #2;
      check_all("reset_immediate", 28'h0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_all("reset_held", 28'h0, 32'h0, 1'b0);
      end

      @(negedge clk);
      reset  = 1'b0;
      signal = 26'd1111;
      pc_hi  = 4'h0;
      @(posedge clk); #1;
      check_all("shift_1111", 28'd4444, 32'd4444, 1'b1);

      @(negedge clk);
      signal = 26'd1010;
      @(posedge clk); #1;
      check_all("shift_1010", 28'd4040, 32'd4040, 1'b1);

      @(negedge clk);
      signal = 26'h3FF_FFFF;
      pc_hi  = 4'hA;
      @(posedge clk); #1;
      check_all("full_width", 28'hFFF_FFFC, 32'hAFFF_FFFC, 1'b1);

      // Hold: outputs keep the last capture while idle inputs churn.
      held_out = 28'hFFF_FFFC;
      held_jt  = 32'hAFFF_FFFC;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         valid_in = 1'b0;
         signal   = (i == 2) ? 'x : 26'($urandom);
         pc_hi    = 4'($urandom);
         @(posedge clk); #1;
         check_all("hold", held_out, held_jt, 1'b0);
      end

      @(negedge clk);
      valid_in = 1'b1;
      signal   = 26'h1;
      pc_hi    = 4'h0;
      @(posedge clk); #1;
      check_all("pre_reset_capture", 28'h4, 32'h4, 1'b1);

      // Asynchronous reset pulse between edges.
      #1 reset = 1'b1;
      #1;
      check_all("async_reset", 28'h0, 32'h0, 1'b0);
      #1 reset = 1'b0;

      @(negedge clk);
      signal = 26'h2;
      @(posedge clk); #1;
      check_all("post_reset_capture", 28'h8, 32'h8, 1'b1);

      @(negedge clk);
      valid_in = 1'b0;
      @(posedge clk); #1;
      check_all("post_reset_idle", 28'h8, 32'h8, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
